// File: rtl/llr_frame_loader_pkg.sv
// Shared types and sizing helpers for the LLR frame loader.
// Build option PINGPONG_EN selects the double-buffered variant in the other files.
package llr_frame_loader_pkg;

  localparam int DEF_DATA_W = 5;

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  function automatic int frame_w(input int nch, input int depth, input int data_w);
    return nch * depth * data_w;
  endfunction

  // Counter must reach DEPTH itself, not just DEPTH-1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/llr_frame_loader_chan_buf.sv
// One lane of the frame loader: shift register plus fill counter.
// With PINGPONG_EN defined the lane carries two banks; fill_sel picks the one being written.
module llr_frame_loader_chan_buf
  import llr_frame_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 18
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef PINGPONG_EN
  input  logic                    flush,
  input  logic                    fill_sel,
  input  logic                    swap,
`else
  input  logic                    clr,
`endif
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_llr,
  output logic                    in_ready,
  output logic                    full_next,
  output logic [DEPTH*DATA_W-1:0] data
);

  localparam int CW = cnt_w(DEPTH);
  localparam int LW = DEPTH * DATA_W;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);

  logic accept;

`ifdef PINGPONG_EN
  logic [CW-1:0] cnt_reg   [2];
  logic [LW-1:0] shift_reg [2];
  logic [CW-1:0] fill_cnt;

  assign fill_cnt  = cnt_reg[fill_sel];
  assign in_ready  = (fill_cnt < FULL_C);
  assign accept    = in_valid & in_ready;
  assign full_next = (fill_cnt == FULL_C) | (accept & (fill_cnt == LAST_C));
  assign data      = shift_reg[~fill_sel];

  // The bank leaving presentation on a swap becomes the next fill bank, so it starts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        cnt_reg[b]   <= '0;
        shift_reg[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (flush) begin
          cnt_reg[b] <= '0;
        end else if (b[0] == fill_sel) begin
          if (accept) begin
            cnt_reg[b]   <= cnt_reg[b] + 1'b1;
            shift_reg[b] <= (shift_reg[b] << DATA_W) | LW'(in_llr);
          end
        end else if (swap) begin
          cnt_reg[b] <= '0;
        end
      end
    end
  end
`else
  logic [CW-1:0] cnt_reg;
  logic [LW-1:0] shift_reg;

  assign in_ready  = (cnt_reg < FULL_C);
  assign accept    = in_valid & in_ready;
  assign full_next = (cnt_reg == FULL_C) | (accept & (cnt_reg == LAST_C));
  assign data      = shift_reg;

  // Newest symbol enters at the LSB so the first symbol ends up most significant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg   <= cnt_reg + 1'b1;
      shift_reg <= (shift_reg << DATA_W) | LW'(in_llr);
    end
  end
`endif

endmodule

// File: rtl/llr_frame_loader.sv
// Collects NCH LLR lanes of DEPTH symbols into one frame and hands it off via valid/ready.
// Build option PINGPONG_EN: two banks per lane so filling continues while a frame waits.
module llr_frame_loader
  import llr_frame_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NCH    = 128,
  parameter int DEPTH  = 18,
  parameter int CNT_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NCH-1:0]                         in_valid,
  input  logic [NCH*DATA_W-1:0]                  in_llr,
  output logic [NCH-1:0]                         in_ready,
  output logic                                   frame_valid,
  input  logic                                   frame_ready,
  output logic [frame_w(NCH, DEPTH, DATA_W)-1:0] frame_data,
  output logic [CNT_W-1:0]                       frame_cnt,
  output logic                                   stall
);

  localparam int LW = DEPTH * DATA_W;

  state_t         state_reg;
  logic [NCH-1:0] full_next;
  logic           fill_full_next;
  logic           handshake;

  assign fill_full_next = &full_next;
  assign handshake      = frame_valid & frame_ready & ~flush;
  assign frame_valid    = (state_reg == ST_PRESENT);

`ifdef PINGPONG_EN
  logic fill_sel_reg;
  logic swap;

  // A full fill bank may move to presentation when the present slot is free or freeing now.
  assign swap = fill_full_next & (~frame_valid | frame_ready) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FILL;
      fill_sel_reg <= 1'b0;
      frame_cnt    <= '0;
      stall        <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_FILL;
      stall     <= 1'b0;
    end else begin
      if (swap) begin
        fill_sel_reg <= ~fill_sel_reg;
        state_reg    <= ST_PRESENT;
      end else if (handshake) begin
        state_reg <= ST_FILL;
      end
      if (handshake) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      stall <= fill_full_next & ~swap;
    end
  end
`else
  logic clr;

  assign clr = flush | handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FILL;
      frame_cnt <= '0;
      stall     <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_FILL;
      stall     <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (fill_full_next) begin
            state_reg <= ST_PRESENT;
            stall     <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (frame_ready) begin
            state_reg <= ST_FILL;
            stall     <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      endcase
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      logic [LW-1:0] lane_data;

      llr_frame_loader_chan_buf #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
`ifdef PINGPONG_EN
        .flush    (flush),
        .fill_sel (fill_sel_reg),
        .swap     (swap),
`else
        .clr      (clr),
`endif
        .in_valid (in_valid[gi]),
        .in_llr   (in_llr[gi*DATA_W +: DATA_W]),
        .in_ready (in_ready[gi]),
        .full_next(full_next[gi]),
        .data     (lane_data)
      );

      assign frame_data[gi*LW +: LW] = lane_data;
    end
  endgenerate

endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed bench for llr_frame_loader at NCH=4, DEPTH=3; PINGPONG_EN selects the double-bank checks.
module tb_llr_frame_loader;

  localparam int DATA_W = 5;
  localparam int NCH    = 4;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 16;
  localparam int FW     = NCH * DEPTH * DATA_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [NCH-1:0]        in_valid;
  logic [NCH*DATA_W-1:0] in_llr;
  logic [NCH-1:0]        in_ready;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [FW-1:0]         frame_data;
  logic [CNT_W-1:0]      frame_cnt;
  logic                  stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] msym [NCH][DEPTH];
  int                mc   [NCH];

  typedef struct {
    logic [NCH-1:0]    v;
    logic [DATA_W-1:0] llr;
    logic              fr;
    logic              fl;
    logic [NCH-1:0]    e_rdy;
    logic              e_fv;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_stall;
    logic              chk;
    logic [FW-1:0]     e_data;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  llr_frame_loader #(
    .DATA_W(DATA_W),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_llr     (in_llr),
    .in_ready   (in_ready),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .frame_cnt  (frame_cnt),
    .stall      (stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*DATA_W-1:0] rep(input logic [DATA_W-1:0] v);
    logic [NCH*DATA_W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  // Every lane holds a,b,c with a in the most significant slot.
  function automatic logic [FW-1:0] pack3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                          input logic [DATA_W-1:0] c);
    logic [FW-1:0] f;
    for (int i = 0; i < NCH; i++) f[i*DEPTH*DATA_W +: DEPTH*DATA_W] = {a, b, c};
    return f;
  endfunction

  function automatic logic [FW-1:0] build_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < DEPTH; j++)
        f[(i*DEPTH + DEPTH-1-j)*DATA_W +: DATA_W] = msym[i][j];
    return f;
  endfunction

  initial begin
    logic [NCH-1:0]    exp_rdy;
    logic              all_full;
    logic [DATA_W-1:0] s;

    rst = 1'b1; flush = 1'b0; frame_ready = 1'b0; in_valid = '0; in_llr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fv", frame_valid, 0);
    check("rst_rdy", in_ready, 4'hF);
    check("rst_cnt", frame_cnt, 0);
    check("rst_stall", stall, 0);
    check("rst_data", frame_data, 0);
    rst = 1'b0;

`ifndef PINGPONG_EN
    tbl[0] = '{v:4'hF, llr:5'd1, fr:0, fl:0, e_rdy:4'hF, e_fv:0, e_cnt:0, e_stall:0, chk:0, e_data:'0};
    tbl[1] = '{v:4'hF, llr:5'd2, fr:0, fl:0, e_rdy:4'hF, e_fv:0, e_cnt:0, e_stall:0, chk:0, e_data:'0};
    tbl[2] = '{v:4'hF, llr:5'd3, fr:0, fl:0, e_rdy:4'h0, e_fv:1, e_cnt:0, e_stall:1, chk:1,
               e_data:pack3(5'd1, 5'd2, 5'd3)};
    tbl[3] = '{v:4'hF, llr:5'd7, fr:0, fl:0, e_rdy:4'h0, e_fv:1, e_cnt:0, e_stall:1, chk:1,
               e_data:pack3(5'd1, 5'd2, 5'd3)};
    tbl[4] = '{v:4'hF, llr:5'd7, fr:1, fl:0, e_rdy:4'hF, e_fv:0, e_cnt:1, e_stall:0, chk:0, e_data:'0};
    tbl[5] = '{v:4'h0, llr:5'd0, fr:1, fl:0, e_rdy:4'hF, e_fv:0, e_cnt:1, e_stall:0, chk:0, e_data:'0};
    tbl[6] = '{v:4'hF, llr:5'd9, fr:0, fl:0, e_rdy:4'hF, e_fv:0, e_cnt:1, e_stall:0, chk:0, e_data:'0};
    tbl[7] = '{v:4'hF, llr:5'd9, fr:0, fl:1, e_rdy:4'hF, e_fv:0, e_cnt:1, e_stall:0, chk:0, e_data:'0};

    for (int k = 0; k < 8; k++) begin
      in_valid = tbl[k].v; in_llr = rep(tbl[k].llr); frame_ready = tbl[k].fr; flush = tbl[k].fl;
      step();
      $display("[TB] vec %0d: rdy=%h fv=%0d cnt=%0d stall=%0d", k, in_ready, frame_valid, frame_cnt, stall);
      check($sformatf("v%0d_rdy", k), in_ready, tbl[k].e_rdy);
      check($sformatf("v%0d_fv", k), frame_valid, tbl[k].e_fv);
      check($sformatf("v%0d_cnt", k), frame_cnt, tbl[k].e_cnt);
      check($sformatf("v%0d_stall", k), stall, tbl[k].e_stall);
      if (tbl[k].chk) check($sformatf("v%0d_data", k), frame_data, tbl[k].e_data);
    end
    flush = 1'b0; frame_ready = 1'b0;

    // After the flush at a partial count, the frame must hold only post-flush symbols.
    for (int j = 0; j < DEPTH; j++) begin
      in_valid = 4'hF; in_llr = rep(DATA_W'(4 + j));
      step();
    end
    $display("[TB] post-flush frame: fv=%0d data=%h", frame_valid, frame_data);
    check("pf_fv", frame_valid, 1);
    check("pf_data", frame_data, pack3(5'd4, 5'd5, 5'd6));

    // Backpressure: nothing may move while frame_ready stays low.
    for (int k = 0; k < 10; k++) begin
      in_valid = 4'hF; in_llr = rep(5'd31);
      step();
      check($sformatf("hold%0d_fv", k), frame_valid, 1);
      check($sformatf("hold%0d_stall", k), stall, 1);
      check($sformatf("hold%0d_rdy", k), in_ready, 4'h0);
      check($sformatf("hold%0d_data", k), frame_data, pack3(5'd4, 5'd5, 5'd6));
    end
    $display("[TB] hold done: cnt=%0d", frame_cnt);

    // Flush beats a simultaneous handshake: frame dropped, not counted.
    in_valid = '0; flush = 1'b1; frame_ready = 1'b1;
    step();
    flush = 1'b0; frame_ready = 1'b0;
    $display("[TB] flush+ready: fv=%0d cnt=%0d", frame_valid, frame_cnt);
    check("fh_fv", frame_valid, 0);
    check("fh_cnt", frame_cnt, 1);
    check("fh_stall", stall, 0);
    check("fh_rdy", in_ready, 4'hF);

    // Lane 2 valid once per 5 cycles, the others every cycle.
    for (int i = 0; i < NCH; i++) mc[i] = 0;
    for (int c = 0; c <= 10; c++) begin
      exp_rdy = '0;
      for (int i = 0; i < NCH; i++) exp_rdy[i] = (mc[i] < DEPTH);
      check($sformatf("slow%0d_rdy", c), in_ready, exp_rdy);
      for (int i = 0; i < NCH; i++) begin
        in_valid[i] = (i != 2) || (c % 5 == 0);
        s = DATA_W'(c*3 + i - 8);
        in_llr[i*DATA_W +: DATA_W] = s;
        if (in_valid[i] && mc[i] < DEPTH) begin
          msym[i][mc[i]] = s;
          mc[i]++;
        end
      end
      step();
      all_full = 1'b1;
      for (int i = 0; i < NCH; i++) if (mc[i] != DEPTH) all_full = 1'b0;
      $display("[TB] slow cycle %0d: rdy=%h fv=%0d", c, in_ready, frame_valid);
      check($sformatf("slow%0d_fv", c), frame_valid, all_full);
    end
    in_valid = '0;
    check("slow_data", frame_data, build_frame());
    check("slow_stall", stall, 1);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    $display("[TB] slow handshake: cnt=%0d", frame_cnt);
    check("slow_cnt", frame_cnt, 2);
    check("slow_fv_after", frame_valid, 0);

    // Asynchronous reset partway through a frame.
    for (int j = 0; j < 2; j++) begin
      in_valid = 4'hF; in_llr = rep(5'd8);
      step();
    end
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    $display("[TB] async rst: cnt=%0d data=%h", frame_cnt, frame_data);
    check("arst_cnt", frame_cnt, 0);
    check("arst_data", frame_data, 0);
    check("arst_rdy", in_ready, 4'hF);
    check("arst_fv", frame_valid, 0);
    step();
    rst = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      in_valid = 4'hF; in_llr = rep(DATA_W'(j + 1));
      step();
    end
    in_valid = '0;
    check("arst2_fv", frame_valid, 1);
    check("arst2_data", frame_data, pack3(5'd1, 5'd2, 5'd3));
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    $display("[TB] post-reset handshake: cnt=%0d", frame_cnt);
    check("arst2_cnt", frame_cnt, 1);
`else
    // Continuous input with frame_ready high: no fill gaps, one frame per DEPTH cycles.
    frame_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("pp%0d_rdy", c), in_ready, 4'hF);
      in_valid = 4'hF; in_llr = rep(DATA_W'(c % 3 + 1));
      step();
      $display("[TB] pp cycle %0d: fv=%0d cnt=%0d", c, frame_valid, frame_cnt);
      check($sformatf("pp%0d_fv", c), frame_valid, ((c + 1) % 3 == 0));
      check($sformatf("pp%0d_cnt", c), frame_cnt, c / 3);
      if ((c + 1) % 3 == 0) check($sformatf("pp%0d_data", c), frame_data, pack3(5'd1, 5'd2, 5'd3));
    end
    // Both banks full with no handshake: inputs blocked and stall raised.
    frame_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 4'hF; in_llr = rep(5'd9);
      step();
    end
    $display("[TB] pp stall: rdy=%h stall=%0d", in_ready, stall);
    check("pp_full_rdy", in_ready, 4'h0);
    check("pp_full_stall", stall, 1);
    check("pp_full_fv", frame_valid, 1);
    check("pp_full_data", frame_data, pack3(5'd1, 5'd2, 5'd3));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
